// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC generation, synchronous-ROM addressing and a DEPTH-entry {instr, pc} queue.
// Latency: an address issued at one edge is written at the next edge and is visible at the head right after it.
// Backpressure: ready_in=0 holds the head; fetch stops once queued + in-flight words fill DEPTH, so nothing is dropped.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-low reset
//   flush, redirect_target - branch redirect from decode; empties the queue and issues the target this cycle
//   ready_in              - decode accepts the head entry
//   rom_address / rom_q   - ROM address (combinational) and data returned one cycle later
//   valid_out, instr_out, pc_out, count_out - queue head (zeros when empty) and occupancy
module fetch_queue_unit #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 20,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          redirect_target,
  input  logic                       ready_in,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [INSTR_W-1:0]         rom_q,
  output logic                       valid_out,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];

  logic               deq;
  logic               wr;
  logic               issue;
  logic [CNT_W:0]     occ_after;

  assign valid_out   = (count != '0);
  assign instr_out   = valid_out ? q_instr[rd_ptr] : '0;
  assign pc_out      = valid_out ? q_pc[rd_ptr]    : '0;
  assign count_out   = count;

  assign rom_address = flush ? redirect_target : fetch_pc;

  // A redirect wins over decode's accept: the head is being thrown away anyway.
  assign deq = valid_out & ready_in & ~flush;
  // The response landing at a flush edge belongs to the wrong path.
  assign wr  = inflight & ~flush;

  // Occupancy counting the word still in the ROM; issuing only below DEPTH
  // keeps a slot reserved for every outstanding fetch, so the queue cannot overflow.
  assign occ_after = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(deq);
  assign issue     = flush | (occ_after < (CNT_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= rom_address + ADDR_W'(PC_STEP);
        inflight_pc <= rom_address;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr) - CNT_W'(deq);
    end
  end

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (wr) begin
      q_instr[wr_ptr] <= rom_q;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end for the pipelined scalar/vector CPU. It replaces the fixed 16-bit PC register, PC adder and PC mux with a single block. The block drives a synchronous ROM and buffers returned instructions in a DEPTH-entry queue, so a decode stall never drops or replays a fetched word. A branch redirect from decode flushes the queue and issues the target address in the same cycle.

## Interface
- ADDR_W, 16: PC / ROM address width.
- INSTR_W, 20: instruction width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 0: first fetch address after reset.
- PC_STEP, 1: PC increment per fetch.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  branch taken in decode; redirect this cycle.
- redirect_target  in  ADDR_W  branch target; sampled only when flush=1.
- ready_in  in  1  decode accepts the head entry (0 = hazard stall).
- rom_address  out  ADDR_W  combinational: flush ? redirect_target : fetch_pc.
- rom_q  in  INSTR_W  ROM data, valid one cycle after the address is sampled.
- valid_out  out  1  queue head is valid.
- instr_out  out  INSTR_W  head instruction; all zeros when valid_out=0 (nop).
- pc_out  out  ADDR_W  PC of the head instruction; zero when valid_out=0.
- count_out  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- State: fetch_pc, inflight bit with its inflight_pc, a circular queue of {instr, pc}, read/write pointers and count.
- Reset (asynchronous, any time): fetch_pc=RESET_PC, inflight=0, pointers=0, count=0. Outputs go to valid_out=0, instr_out=0, pc_out=0, count_out=0 and rom_address=RESET_PC. Queue contents are don't-care.
- deq = valid_out & ready_in & ~flush.
- issue = flush | (count + inflight - deq < DEPTH).
- On issue: the ROM samples rom_address. fetch_pc <= rom_address + PC_STEP, modulo 2^ADDR_W (wrap 0xFFFF -> 0x0000 at 16 bits). inflight <= 1 and inflight_pc <= rom_address.
- On no issue: fetch_pc holds, inflight <= 0, and rom_address stays stable.
- Response: if inflight=1 and flush=0 at an edge, {rom_q, inflight_pc} is written at the write pointer and count increments.
- Simultaneous write and deq leaves count unchanged. Pointers wrap modulo DEPTH.
- Flush has priority over everything at its edge:
  - Queue emptied: pointers=0, count=0.
  - The response arriving at that edge is discarded.
  - redirect_target is issued and fetch_pc <= redirect_target + PC_STEP.
- ready_in is ignored while flush=1.
- Back-to-back flushes: each edge redirects and discards the previous target's response.
- Overflow is structurally impossible: the issue rule reserves a slot for every in-flight word. Underflow is impossible because deq requires valid_out.

## Timing
- Fetch-to-output latency is 2 edges. An address issued at edge Ek is written at Ek+1 and is visible on valid_out/instr_out after Ek+1.
- First edge after reset release (E1) issues RESET_PC. valid_out=1 after E2 with pc_out=RESET_PC.
- Throughput is one instruction per cycle when ready_in=1 continuously, with no bubbles.
- Redirect penalty: the target appears at the head 2 edges after the flush edge. Exactly one bubble (valid_out=0) is seen by decode in between.
- With ready_in=0, issue stops once count+inflight=DEPTH. Output fields stay stable while stalled.
- When ready_in rises on a full queue, the dequeue and a new issue happen at the same edge.

## Test plan
- Reset, ROM word[i]=i+0x100, ready_in=1 → after E2: valid_out=1, pc_out=0, instr_out=0x00100. pc_out then increments by 1 each cycle with no gaps.
- DEPTH=4, ready_in=0 from reset → issues at E1-E4 (addresses 0-3). After E5: count_out=4, rom_address=4, head pc_out=0. Raise ready_in → outputs pc 0,1,2,3,4… consecutively.
- Steady stream, flush=1 with redirect_target=0x0020 at edge Ef → rom_address=0x0020 during that cycle. After Ef: count_out=0, valid_out=0. After Ef+1: pc_out=0x0020. No pre-flush pc appears after Ef.
- Flush on two consecutive edges (targets 0x0010, then 0x0030) → 0x0010 is never output. First valid pc_out=0x0030.
- RESET_PC=0xFFFE, ADDR_W=16 → output pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Assert reset low asynchronously mid-stream with count_out=3 → valid_out, count_out and instr_out go to 0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC with 2-edge latency.
